// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared state, move, select and color codes for the maze controller
package maze_pkg;

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_INIT_DRAW = 4'd1,
        ST_IDLE      = 4'd2,
        ST_PROBE     = 4'd3,
        ST_WAIT      = 4'd4,
        ST_CHECK     = 4'd5,
        ST_ERASE     = 4'd6,
        ST_STEP      = 4'd7,
        ST_DRAW      = 4'd8,
        ST_GOALCHK   = 4'd9,
        ST_HOLD_CLR  = 4'd10,
        ST_HOLD      = 4'd11,
        ST_WON       = 4'd12
    } state_e;

    localparam logic [2:0] MV_NONE  = 3'd0;
    localparam logic [2:0] MV_LEFT  = 3'd1;
    localparam logic [2:0] MV_RIGHT = 3'd2;
    localparam logic [2:0] MV_UP    = 3'd3;
    localparam logic [2:0] MV_DOWN  = 3'd4;

    localparam logic [1:0] SEL_INIT = 2'd0;
    localparam logic [1:0] SEL_INC  = 2'd1;
    localparam logic [1:0] SEL_DEC  = 2'd2;

    localparam logic COL_ERASE  = 1'b0;
    localparam logic COL_PLAYER = 1'b1;

endpackage

// File: rtl/maze_ctrl.sv
// rtl/maze_ctrl.sv - Moore FSM sequencing the maze-game datapath
module maze_ctrl
    import maze_pkg::*;
#(
    parameter int         MEM_LAT = 2,
    parameter logic [7:0] GOAL_X  = 8'h05,
    parameter logic [6:0] GOAL_Y  = 7'h02
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] move,
    input  logic       obs_block,
    input  logic       timer_done,
    input  logic [7:0] xpos,
    input  logic [6:0] ypos,
    output logic       en_xpos,
    output logic       en_ypos,
    output logic [1:0] s_xpos,
    output logic [1:0] s_ypos,
    output logic       en_key,
    output logic       s_key,
    output logic       en_obs,
    output logic [2:0] s_obs,
    output logic       s_color,
    output logic       plot,
    output logic       en_timer,
    output logic       s_timer,
    output logic       busy,
    output logic       did_win
);

    // Counter sized to hold MEM_LAT-1; at MEM_LAT=1 it loads 0 so WAIT lasts one cycle.
    localparam int            CW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(MEM_LAT - 1);

    state_e        state_q, state_d;
    logic [2:0]    dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State, latched direction and memory-latency counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_RESET;
            dir_q   <= MV_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: one accepted key walks the probe/erase/step/draw sequence.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET:     state_d = ST_INIT_DRAW;
            ST_INIT_DRAW: state_d = ST_IDLE;
            ST_IDLE: begin
                if (move != MV_NONE) begin
                    dir_d   = move;
                    state_d = ST_PROBE;
                end
            end
            ST_PROBE: begin
                cnt_d   = WAIT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_CHECK:     state_d = obs_block ? ST_HOLD_CLR : ST_ERASE;
            ST_ERASE:     state_d = ST_STEP;
            ST_STEP:      state_d = ST_DRAW;
            ST_DRAW:      state_d = ST_GOALCHK;
            ST_GOALCHK: begin
                if (xpos == GOAL_X && ypos == GOAL_Y) begin
                    state_d = ST_WON;
                end else begin
                    state_d = ST_HOLD_CLR;
                end
            end
            ST_HOLD_CLR:  state_d = ST_HOLD;
            ST_HOLD: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WON:       state_d = ST_WON;
            default:      state_d = ST_RESET;
        endcase
    end

    // Output decode: every output is a pure function of the current state.
    always_comb begin
        en_xpos  = 1'b0;
        en_ypos  = 1'b0;
        s_xpos   = SEL_INIT;
        s_ypos   = SEL_INIT;
        en_key   = 1'b0;
        s_key    = 1'b0;
        en_obs   = 1'b0;
        s_obs    = MV_NONE;
        s_color  = COL_ERASE;
        plot     = 1'b0;
        en_timer = 1'b0;
        s_timer  = 1'b0;
        busy     = 1'b1;
        did_win  = 1'b0;
        case (state_q)
            ST_RESET: begin
                en_xpos  = 1'b1;
                en_ypos  = 1'b1;
                en_timer = 1'b1;
            end
            ST_INIT_DRAW: begin
                plot    = 1'b1;
                s_color = COL_PLAYER;
            end
            ST_IDLE: begin
                en_key = 1'b1;
                s_key  = 1'b1;
                busy   = 1'b0;
            end
            ST_PROBE: begin
                en_obs = 1'b1;
                s_obs  = dir_q;
                en_key = 1'b1;
            end
            ST_ERASE: begin
                plot    = 1'b1;
                s_color = COL_ERASE;
            end
            ST_STEP: begin
                case (dir_q)
                    MV_LEFT: begin
                        en_xpos = 1'b1;
                        s_xpos  = SEL_DEC;
                    end
                    MV_RIGHT: begin
                        en_xpos = 1'b1;
                        s_xpos  = SEL_INC;
                    end
                    MV_UP: begin
                        en_ypos = 1'b1;
                        s_ypos  = SEL_DEC;
                    end
                    MV_DOWN: begin
                        en_ypos = 1'b1;
                        s_ypos  = SEL_INC;
                    end
                    default: ;
                endcase
            end
            ST_DRAW: begin
                plot    = 1'b1;
                s_color = COL_PLAYER;
            end
            ST_HOLD_CLR: begin
                en_timer = 1'b1;
            end
            ST_HOLD: begin
                en_timer = 1'b1;
                s_timer  = 1'b1;
            end
            ST_WON: begin
                did_win = 1'b1;
                busy    = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_maze_ctrl.sv
// tb/tb_maze_ctrl.sv - self-checking bench for maze_ctrl with a datapath and game model
module tb_maze_ctrl;
    import maze_pkg::*;

    localparam logic [7:0] GX = 8'h05;
    localparam logic [6:0] GY = 7'h02;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn = 1'b0;
    logic [2:0] move = 3'd0;
    logic       obs_block = 1'b0;
    logic       timer_done;
    logic [7:0] xpos;
    logic [6:0] ypos;
    logic       en_xpos, en_ypos, en_key, s_key, en_obs, s_color, plot;
    logic       en_timer, s_timer, busy, did_win;
    logic [1:0] s_xpos, s_ypos;
    logic [2:0] s_obs;

    logic [2:0] move1 = 3'd0;
    logic       obs1 = 1'b0;
    logic       tdone1 = 1'b0;
    logic [7:0] xpos1 = 8'h40;
    logic [6:0] ypos1 = 7'h40;
    logic       en_xpos1, en_ypos1, en_key1, s_key1, en_obs1, s_color1, plot1;
    logic       en_timer1, s_timer1, busy1, did_win1;
    logic [1:0] s_xpos1, s_ypos1;
    logic [2:0] s_obs1;

    int checks = 0;
    int errors = 0;

    maze_ctrl #(.MEM_LAT(2), .GOAL_X(GX), .GOAL_Y(GY)) dut (
        .clk(clk), .resetn(resetn), .move(move), .obs_block(obs_block),
        .timer_done(timer_done), .xpos(xpos), .ypos(ypos),
        .en_xpos(en_xpos), .en_ypos(en_ypos), .s_xpos(s_xpos), .s_ypos(s_ypos),
        .en_key(en_key), .s_key(s_key), .en_obs(en_obs), .s_obs(s_obs),
        .s_color(s_color), .plot(plot), .en_timer(en_timer), .s_timer(s_timer),
        .busy(busy), .did_win(did_win)
    );

    maze_ctrl #(.MEM_LAT(1), .GOAL_X(GX), .GOAL_Y(GY)) dut1 (
        .clk(clk), .resetn(resetn), .move(move1), .obs_block(obs1),
        .timer_done(tdone1), .xpos(xpos1), .ypos(ypos1),
        .en_xpos(en_xpos1), .en_ypos(en_ypos1), .s_xpos(s_xpos1), .s_ypos(s_ypos1),
        .en_key(en_key1), .s_key(s_key1), .en_obs(en_obs1), .s_obs(s_obs1),
        .s_color(s_color1), .plot(plot1), .en_timer(en_timer1), .s_timer(s_timer1),
        .busy(busy1), .did_win(did_win1)
    );

    // Game world: wall map, start position, timer limit.
    bit         wall_map [0:255][0:127];
    logic [7:0] xinit = 8'h00;
    logic [6:0] yinit = 7'h00;
    logic [7:0] ox = 8'h00;
    logic [6:0] oy = 7'h00;
    int         tcnt = 0;
    int         tlim = 1;
    logic       timer_auto = 1'b1;
    logic       timer_man = 1'b0;
    logic [7:0] mx;
    logic [6:0] my;

    function automatic logic [7:0] nx(input logic [7:0] x, input logic [2:0] d);
        if (d == MV_LEFT)  return x - 8'd1;
        if (d == MV_RIGHT) return x + 8'd1;
        return x;
    endfunction

    function automatic logic [6:0] ny(input logic [6:0] y, input logic [2:0] d);
        if (d == MV_UP)   return y - 7'd1;
        if (d == MV_DOWN) return y + 7'd1;
        return y;
    endfunction

    assign timer_done = timer_auto ? (tcnt >= tlim) : timer_man;

    // Datapath model: position registers, probe address register, ROM register, timer.
    always @(posedge clk) begin
        if (en_xpos) begin
            case (s_xpos)
                SEL_INIT: xpos <= xinit;
                SEL_INC:  xpos <= xpos + 8'd1;
                SEL_DEC:  xpos <= xpos - 8'd1;
                default:  ;
            endcase
        end
        if (en_ypos) begin
            case (s_ypos)
                SEL_INIT: ypos <= yinit;
                SEL_INC:  ypos <= ypos + 7'd1;
                SEL_DEC:  ypos <= ypos - 7'd1;
                default:  ;
            endcase
        end
        if (en_obs) begin
            ox <= nx(xpos, s_obs);
            oy <= ny(ypos, s_obs);
        end
        obs_block <= wall_map[ox][oy];
        if (en_timer) tcnt <= s_timer ? tcnt + 1 : 0;
    end

    task automatic apply_reset(input logic [7:0] x, input logic [6:0] y);
        xinit  = x;
        yinit  = y;
        move   = MV_NONE;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mx = x;
        my = y;
    endtask

    task automatic test_reset;
        xinit  = 8'h86;
        yinit  = 7'h77;
        move   = MV_NONE;
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({en_xpos, en_ypos, s_xpos, s_ypos, en_timer, s_timer, busy, plot, did_win, en_key}
            !== {1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_strobes: got en_x=%b en_y=%b sx=%0d sy=%0d en_t=%b s_t=%b busy=%b plot=%b win=%b",
                     en_xpos, en_ypos, s_xpos, s_ypos, en_timer, s_timer, busy, plot, did_win);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({plot, s_color, xpos, ypos} !== {1'b1, 1'b1, 8'h86, 7'h77}) begin
            errors++;
            $display("FAIL init_draw: got plot=%b color=%b pos=(%h,%h), expected plot=1 color=1 pos=(86,77)",
                     plot, s_color, xpos, ypos);
        end
        @(posedge clk); #1;
        checks++;
        if ({en_key, s_key, busy, did_win, plot} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle: got en_key=%b s_key=%b busy=%b win=%b plot=%b, expected 1 1 0 0 0",
                     en_key, s_key, busy, did_win, plot);
        end
        mx = 8'h86;
        my = 7'h77;
    endtask

    // One key press from IDLE, compared against the game rules and the sequence timing.
    task automatic do_move(input logic [2:0] dir, input int lim);
        logic [7:0] tx, old_x;
        logic [6:0] ty, old_y;
        bit         blocked, won, step_y, exp_y;
        int         exp_idle, obs_cyc, nplot, nstep, idle_cyc, step_c;
        logic [2:0] obs_sel;
        logic [1:0] step_sel, exp_sel;
        int         pc [4];
        logic       pcol [4];
        logic [7:0] px [4];
        logic [6:0] py [4];
        old_x    = mx;
        old_y    = my;
        tx       = nx(mx, dir);
        ty       = ny(my, dir);
        blocked  = wall_map[tx][ty];
        won      = !blocked && tx == GX && ty == GY;
        exp_idle = blocked ? 7 + lim : (won ? 9 : 11 + lim);
        exp_y    = (dir == MV_UP || dir == MV_DOWN);
        exp_sel  = (dir == MV_RIGHT || dir == MV_DOWN) ? SEL_INC : SEL_DEC;
        timer_auto = 1'b1;
        tlim     = lim;
        obs_cyc  = -1;
        nplot    = 0;
        nstep    = 0;
        idle_cyc = -1;
        step_c   = -1;
        obs_sel  = 3'd0;
        step_y   = 1'b0;
        step_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            pc[i] = -1; pcol[i] = 1'b0; px[i] = 8'h0; py[i] = 7'h0;
        end
        move = dir;
        for (int c = 1; c <= 80 && idle_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) move = MV_NONE;
            if (en_obs && obs_cyc < 0) begin
                obs_cyc = c;
                obs_sel = s_obs;
            end
            if (plot) begin
                if (nplot < 4) begin
                    pc[nplot] = c; pcol[nplot] = s_color; px[nplot] = xpos; py[nplot] = ypos;
                end
                nplot++;
            end
            if (en_xpos || en_ypos) begin
                nstep++;
                step_c   = c;
                step_y   = en_ypos;
                step_sel = en_ypos ? s_ypos : s_xpos;
            end
            if (!busy) idle_cyc = c;
        end
        checks++;
        if (obs_cyc != 1 || obs_sel !== dir) begin
            errors++;
            $display("FAIL probe dir=%0d: en_obs at cycle %0d sel %0d, expected cycle 1 sel %0d",
                     dir, obs_cyc, obs_sel, dir);
        end
        checks++;
        if (nplot != (blocked ? 0 : 2) || nstep != (blocked ? 0 : 1)) begin
            errors++;
            $display("FAIL activity dir=%0d blocked=%0d: %0d plots %0d steps, expected %0d plots %0d steps",
                     dir, blocked, nplot, nstep, blocked ? 0 : 2, blocked ? 0 : 1);
        end
        if (!blocked && nplot == 2) begin
            checks++;
            if (pc[0] != 5 || pcol[0] !== COL_ERASE || px[0] !== old_x || py[0] !== old_y) begin
                errors++;
                $display("FAIL erase dir=%0d: cycle %0d color %b at (%h,%h), expected cycle 5 color 0 at (%h,%h)",
                         dir, pc[0], pcol[0], px[0], py[0], old_x, old_y);
            end
            checks++;
            if (pc[1] != 7 || pcol[1] !== COL_PLAYER || px[1] !== tx || py[1] !== ty) begin
                errors++;
                $display("FAIL draw dir=%0d: cycle %0d color %b at (%h,%h), expected cycle 7 color 1 at (%h,%h)",
                         dir, pc[1], pcol[1], px[1], py[1], tx, ty);
            end
            checks++;
            if (step_c != 6 || step_y !== exp_y || step_sel !== exp_sel) begin
                errors++;
                $display("FAIL step dir=%0d: cycle %0d y_axis %b sel %0d, expected cycle 6 y_axis %b sel %0d",
                         dir, step_c, step_y, step_sel, exp_y, exp_sel);
            end
        end
        if (!blocked) begin
            mx = tx;
            my = ty;
        end
        checks++;
        if (idle_cyc != exp_idle) begin
            errors++;
            $display("FAIL settle dir=%0d lim=%0d: not busy at cycle %0d, expected %0d", dir, lim, idle_cyc, exp_idle);
        end
        checks++;
        if (xpos !== mx || ypos !== my || did_win !== won) begin
            errors++;
            $display("FAIL position dir=%0d: at (%h,%h) win=%b, expected (%h,%h) win=%b",
                     dir, xpos, ypos, did_win, mx, my, won);
        end
    endtask

    task automatic test_clear_move;
        apply_reset(8'h86, 7'h77);
        wall_map[8'h87][7'h77] = 1'b0;
        do_move(MV_RIGHT, 2);
    endtask

    task automatic test_blocked;
        wall_map[mx][my - 7'd1] = 1'b1;
        do_move(MV_UP, 3);
    endtask

    task automatic test_hold_keys;
        int n_obs, n_plot;
        apply_reset(8'h86, 7'h77);
        wall_map[8'h85][7'h77] = 1'b1;
        timer_auto = 1'b0;
        timer_man  = 1'b0;
        n_obs  = 0;
        n_plot = 0;
        move = MV_LEFT;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            move = (c % 2 == 0) ? MV_LEFT : MV_NONE;
            if (en_obs) n_obs++;
            if (plot) n_plot++;
        end
        checks++;
        if (n_obs != 1 || n_plot != 0 || !(en_timer && s_timer && busy)) begin
            errors++;
            $display("FAIL hold_keys: %0d probes %0d plots en_t=%b s_t=%b busy=%b, expected 1 probe 0 plots in HOLD",
                     n_obs, n_plot, en_timer, s_timer, busy);
        end
        move = MV_NONE;
        timer_man = 1'b1;
        @(posedge clk); #1;
        timer_man = 1'b0;
        checks++;
        if (busy !== 1'b0 || en_key !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: busy=%b en_key=%b, expected 0 1", busy, en_key);
        end
        wall_map[8'h87][7'h77] = 1'b0;
        do_move(MV_RIGHT, 1);
    endtask

    task automatic test_win;
        int bad;
        apply_reset(GX + 8'd1, GY);
        wall_map[GX][GY] = 1'b0;
        do_move(MV_LEFT, 2);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            move = 3'($urandom_range(1, 4));
            @(posedge clk); #1;
            if (en_key || plot || en_obs || !did_win || busy) bad++;
        end
        move = MV_NONE;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL won_absorb: %0d cycles left the won state, expected 0", bad);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        checks++;
        if (did_win !== 1'b0 || en_xpos !== 1'b1) begin
            errors++;
            $display("FAIL win_reset: did_win=%b en_xpos=%b, expected 0 1", did_win, en_xpos);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        apply_reset(8'h40, 7'h40);
        wall_map[8'h41][7'h40] = 1'b0;
        move = MV_RIGHT;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            move = MV_NONE;
        end
        checks++;
        if (plot !== 1'b1 || s_color !== COL_ERASE) begin
            errors++;
            $display("FAIL mid_erase: plot=%b color=%b, expected 1 0", plot, s_color);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        checks++;
        if ({en_xpos, en_ypos, s_xpos, s_ypos, en_timer, s_timer, plot, did_win}
            !== {1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: en_x=%b en_y=%b sx=%0d sy=%0d en_t=%b s_t=%b plot=%b win=%b",
                     en_xpos, en_ypos, s_xpos, s_ypos, en_timer, s_timer, plot, did_win);
        end
        @(posedge clk); #1;
        checks++;
        if (plot !== 1'b1 || s_color !== COL_PLAYER || xpos !== 8'h40 || ypos !== 7'h40) begin
            errors++;
            $display("FAIL mid_init_draw: plot=%b color=%b pos=(%h,%h), expected 1 1 (40,40)",
                     plot, s_color, xpos, ypos);
        end
        @(posedge clk); #1;
        mx = 8'h40;
        my = 7'h40;
    endtask

    task automatic test_memlat1;
        tdone1 = 1'b0;
        obs1   = 1'b0;
        move1  = MV_RIGHT;
        @(posedge clk); #1;
        move1 = MV_NONE;
        checks++;
        if (en_obs1 !== 1'b1 || s_obs1 !== MV_RIGHT) begin
            errors++;
            $display("FAIL lat1_probe: en_obs=%b sel=%0d, expected 1 2", en_obs1, s_obs1);
        end
        @(posedge clk); #1;
        obs1 = 1'b1;
        @(posedge clk); #1;
        obs1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (plot1 !== 1'b1 || s_color1 !== COL_ERASE) begin
            errors++;
            $display("FAIL lat1_glitch: plot=%b color=%b, expected erase plot 1 0", plot1, s_color1);
        end
        tdone1 = 1'b1;
        for (int c = 0; c < 20 && busy1; c++) begin
            @(posedge clk); #1;
        end
        tdone1 = 1'b0;
        move1  = MV_DOWN;
        @(posedge clk); #1;
        move1 = MV_NONE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        obs1 = 1'b1;
        @(posedge clk); #1;
        obs1 = 1'b0;
        checks++;
        if (en_timer1 !== 1'b1 || s_timer1 !== 1'b0 || plot1 !== 1'b0) begin
            errors++;
            $display("FAIL lat1_reject: en_t=%b s_t=%b plot=%b, expected hold-clear 1 0 0",
                     en_timer1, s_timer1, plot1);
        end
        tdone1 = 1'b1;
        for (int c = 0; c < 20 && busy1; c++) begin
            @(posedge clk); #1;
        end
        tdone1 = 1'b0;
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL lat1_return: busy=%b, expected 0", busy1);
        end
    endtask

    task automatic test_random;
        for (int x = 8'h30; x <= 8'h50; x++) begin
            for (int y = 7'h30; y <= 7'h50; y++) begin
                wall_map[x][y] = ($urandom_range(0, 99) < 30);
            end
        end
        wall_map[8'h40][7'h40] = 1'b0;
        apply_reset(8'h40, 7'h40);
        for (int i = 0; i < 40; i++) begin
            do_move(3'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clear_move();
        test_blocked();
        test_hold_keys();
        test_win();
        test_reset_mid();
        test_memlat1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
